// File: rtl/mem_bus_bridge_if.sv
// Signal bundle between the core's memory port and the SoC bus.
// The bridge uses the slave view; the environment around it uses the master view.
interface mem_bus_bridge_if;
    logic        cpu_valid;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [3:0]  cpu_wstrb;
    logic        cpu_ready;
    logic [31:0] cpu_rdata;
    logic        cpu_fault;
    logic        bus_valid;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_wstrb;
    logic        bus_ready;
    logic [31:0] bus_rdata;

    modport slave (
        input  cpu_valid, cpu_addr, cpu_wdata, cpu_wstrb, bus_ready, bus_rdata,
        output cpu_ready, cpu_rdata, cpu_fault, bus_valid, bus_addr, bus_wdata, bus_wstrb
    );

    modport master (
        output cpu_valid, cpu_addr, cpu_wdata, cpu_wstrb, bus_ready, bus_rdata,
        input  cpu_ready, cpu_rdata, cpu_fault, bus_valid, bus_addr, bus_wdata, bus_wstrb
    );
endinterface

// File: rtl/mem_bus_bridge.sv
// Registered bridge from the multicycle core's memory port to the SoC bus.
// Captures one request, runs a valid/ready bus transfer, and returns a
// one-cycle completion pulse with read data or a timeout fault.
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | waiting for cpu_valid; captures the request into bus_* regs
// S_REQ  | bus_valid high, waiting for bus_ready or the wait timeout
// S_RESP | cpu_ready pulse; no new request is taken in this cycle
module mem_bus_bridge #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_WIDTH      = 11
) (
    input  logic             clk,
    input  logic             reset,
    mem_bus_bridge_if.slave  io
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    // TIMEOUT_CYCLES of 0 disables the timeout; TO_LAST is then unused.
    localparam bit                   TO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_WIDTH-1:0] TO_LAST = TO_EN ? CNT_WIDTH'(TIMEOUT_CYCLES - 1) : '0;

    state_t               r_state;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic                 r_bus_valid;
    logic [31:0]          r_bus_addr;
    logic [31:0]          r_bus_wdata;
    logic [3:0]           r_bus_wstrb;
    logic                 r_cpu_ready;
    logic [31:0]          r_cpu_rdata;
    logic                 r_cpu_fault;

    logic                 w_is_read;
    logic                 w_timeout;
    logic                 w_cnt_sat;

    assign w_is_read = (r_bus_wstrb == 4'b0000);
    assign w_timeout = TO_EN && (r_cnt == TO_LAST);
    assign w_cnt_sat = (r_cnt == {CNT_WIDTH{1'b1}});

    // Request/response sequencing; every output is a register so no path
    // runs combinationally from the bus side to the CPU side.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_bus_valid <= 1'b0;
            r_bus_addr  <= '0;
            r_bus_wdata <= '0;
            r_bus_wstrb <= '0;
            r_cpu_ready <= 1'b0;
            r_cpu_rdata <= '0;
            r_cpu_fault <= 1'b0;
        end else begin
            r_cpu_ready <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (io.cpu_valid) begin
                        r_bus_addr  <= io.cpu_addr;
                        r_bus_wdata <= io.cpu_wdata;
                        r_bus_wstrb <= io.cpu_wstrb;
                        r_cnt       <= '0;
                        r_bus_valid <= 1'b1;
                        r_state     <= S_REQ;
                    end
                end
                S_REQ: begin
                    // bus_ready takes priority over a timeout in the same cycle
                    if (io.bus_ready) begin
                        r_cpu_rdata <= w_is_read ? io.bus_rdata : 32'h0;
                        r_cpu_fault <= 1'b0;
                        r_bus_valid <= 1'b0;
                        r_cpu_ready <= 1'b1;
                        r_state     <= S_RESP;
                    end else if (w_timeout) begin
                        r_cpu_rdata <= 32'h0;
                        r_cpu_fault <= 1'b1;
                        r_bus_valid <= 1'b0;
                        r_cpu_ready <= 1'b1;
                        r_state     <= S_RESP;
                    end else if (!w_cnt_sat) begin
                        r_cnt <= r_cnt + CNT_WIDTH'(1);
                    end
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_bus_valid <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign io.bus_valid = r_bus_valid;
    assign io.bus_addr  = r_bus_addr;
    assign io.bus_wdata = r_bus_wdata;
    assign io.bus_wstrb = r_bus_wstrb;
    assign io.cpu_ready = r_cpu_ready;
    assign io.cpu_rdata = r_cpu_rdata;
    assign io.cpu_fault = r_cpu_fault;

endmodule

// File: tb/tb_mem_bus_bridge.sv
// Self-checking bench for mem_bus_bridge: vector table plus hand sequences
// for reset mid-transfer and back-to-back requests; completions are checked
// against a scoreboard queue filled when each request is driven.
module tb_mem_bus_bridge;

    localparam int TO = 8;
    localparam int NEVER = 255;

    logic clk;
    logic reset;
    mem_bus_bridge_if bif ();

    mem_bus_bridge #(.TIMEOUT_CYCLES(TO), .CNT_WIDTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .io    (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          wait_cyc;
        logic [31:0] bus_rdata;
        logic [31:0] exp_rdata;
        logic        exp_fault;
        int          exp_req_cyc;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        fault;
    } sb_t;

    sb_t sb[$];
    int  checks   = 0;
    int  failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Completion monitor: every cpu_ready pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (!reset && bif.cpu_ready) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_completion: got cpu_ready=1 expected no completion at %0t", $time);
            end else begin
                sb_t e;
                e = sb.pop_front();
                check("cpu_rdata", bif.cpu_rdata, e.rdata);
                check("cpu_fault", {31'b0, bif.cpu_fault}, {31'b0, e.fault});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1, "watchdog");
    end

    vec_t vecs[7];

    initial begin
        logic [0:5] exp_bv;
        logic [0:5] exp_cr;

        vecs[0] = '{32'h8000_0010, 32'h0,         4'b0000, 0,     32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 1};
        vecs[1] = '{32'h8000_0020, 32'h1234_0000, 4'b1100, 5,     32'h9999_9999, 32'h0,         1'b0, 6};
        vecs[2] = '{32'h8000_0030, 32'h0,         4'b0000, NEVER, 32'h1111_1111, 32'h0,         1'b1, TO};
        vecs[3] = '{32'h8000_0040, 32'h0,         4'b0000, TO-1,  32'h5A5A_A5A5, 32'h5A5A_A5A5, 1'b0, TO};
        vecs[4] = '{32'h8000_0050, 32'hAABB_CCDD, 4'b1111, 0,     32'hFFFF_FFFF, 32'h0,         1'b0, 1};
        vecs[5] = '{32'h8000_0060, 32'h0000_00EE, 4'b0001, NEVER, 32'h2222_2222, 32'h0,         1'b1, TO};
        vecs[6] = '{32'h8000_0070, 32'h0,         4'b0000, 2,     32'h0000_0001, 32'h0000_0001, 1'b0, 3};

        reset = 1'b1;
        bif.cpu_valid = 1'b0;
        bif.cpu_addr  = '0;
        bif.cpu_wdata = '0;
        bif.cpu_wstrb = '0;
        bif.bus_ready = 1'b0;
        bif.bus_rdata = '0;
        repeat (2) @(negedge clk);
        check("rst_bus_valid", {31'b0, bif.bus_valid}, 32'h0);
        check("rst_cpu_ready", {31'b0, bif.cpu_ready}, 32'h0);
        reset = 1'b0;

        for (int i = 0; i < 7; i++) begin
            int  req_cyc;
            int  guard;
            bit  stable;
            @(negedge clk);
            bif.cpu_valid = 1'b1;
            bif.cpu_addr  = vecs[i].addr;
            bif.cpu_wdata = vecs[i].wdata;
            bif.cpu_wstrb = vecs[i].wstrb;
            bif.bus_rdata = vecs[i].bus_rdata;
            sb.push_back('{vecs[i].exp_rdata, vecs[i].exp_fault});
            @(posedge clk);
            #1;
            // CPU side drops the request and scribbles its inputs; bus regs must hold.
            bif.cpu_valid = 1'b0;
            bif.cpu_addr  = ~vecs[i].addr;
            bif.cpu_wdata = ~vecs[i].wdata;
            bif.cpu_wstrb = ~vecs[i].wstrb;
            @(negedge clk);
            check($sformatf("v%0d_bus_valid_rise", i), {31'b0, bif.bus_valid}, 32'h1);
            req_cyc = 0;
            guard   = 0;
            stable  = 1'b1;
            while (bif.bus_valid && guard < 64) begin
                req_cyc++;
                guard++;
                if (bif.bus_addr !== vecs[i].addr || bif.bus_wdata !== vecs[i].wdata ||
                    bif.bus_wstrb !== vecs[i].wstrb)
                    stable = 1'b0;
                bif.bus_ready = (req_cyc == vecs[i].wait_cyc + 1);
                @(negedge clk);
            end
            bif.bus_ready = 1'b0;
            if (guard >= 64) begin
                checks++;
                failures++;
                $display("FAIL v%0d_req_bound: got bus_valid stuck expected drop within 64 cycles", i);
            end
            check($sformatf("v%0d_bus_hold", i), {31'b0, stable}, 32'h1);
            check($sformatf("v%0d_req_cycles", i), req_cyc, vecs[i].exp_req_cyc);
            check($sformatf("v%0d_cpu_ready", i), {31'b0, bif.cpu_ready}, 32'h1);
            @(negedge clk);
            check($sformatf("v%0d_ready_pulse", i), {31'b0, bif.cpu_ready}, 32'h0);
            check($sformatf("v%0d_rdata_hold", i), bif.cpu_rdata, vecs[i].exp_rdata);
        end

        // Reset asserted asynchronously in the middle of REQ.
        @(negedge clk);
        bif.cpu_valid = 1'b1;
        bif.cpu_addr  = 32'hA5A5_0000;
        bif.cpu_wdata = 32'h7777_7777;
        bif.cpu_wstrb = 4'b0011;
        bif.bus_ready = 1'b0;
        @(posedge clk);
        #1 bif.cpu_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_rst_bus_valid", {31'b0, bif.bus_valid}, 32'h1);
        #2 reset = 1'b1;
        #1;
        check("arst_bus_valid", {31'b0, bif.bus_valid}, 32'h0);
        check("arst_bus_addr", bif.bus_addr, 32'h0);
        check("arst_bus_wdata", bif.bus_wdata, 32'h0);
        check("arst_bus_wstrb", {28'b0, bif.bus_wstrb}, 32'h0);
        check("arst_cpu_ready", {31'b0, bif.cpu_ready}, 32'h0);
        check("arst_cpu_rdata", bif.cpu_rdata, 32'h0);
        check("arst_cpu_fault", {31'b0, bif.cpu_fault}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_idle", {31'b0, bif.bus_valid}, 32'h0);

        // Back-to-back reads with cpu_valid held high and a zero-wait bus.
        exp_bv = 6'b100100;
        exp_cr = 6'b010010;
        bif.bus_ready = 1'b1;
        bif.bus_rdata = 32'hCAFE_F00D;
        bif.cpu_valid = 1'b1;
        bif.cpu_addr  = 32'h0000_0100;
        bif.cpu_wdata = 32'h0;
        bif.cpu_wstrb = 4'b0000;
        sb.push_back('{32'hCAFE_F00D, 1'b0});
        sb.push_back('{32'hCAFE_F00D, 1'b0});
        @(posedge clk);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check($sformatf("b2b_bus_valid_%0d", k), {31'b0, bif.bus_valid}, {31'b0, exp_bv[k]});
            check($sformatf("b2b_cpu_ready_%0d", k), {31'b0, bif.cpu_ready}, {31'b0, exp_cr[k]});
        end
        bif.cpu_valid = 1'b0;
        @(negedge clk);
        check("b2b_no_third", {31'b0, bif.bus_valid}, 32'h0);
        bif.bus_ready = 1'b0;

        repeat (3) @(negedge clk);
        check("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
